phase_sequencer: RTL

- Control FSM that sequences the 2-bit state register (clk/currstate/nextstate) through four phases S0..S3 (00→01→10→11).
- Each phase has a programmable dwell time in clock cycles.
- Supports start, hold, abort and loop control, and reports phase and cycle completion to the surrounding control logic.
- Keeps its own registered copy of the state and exports both the current state and the combinational next state.

---
 rtl/phase_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - four-phase sequencer with per-phase dwell timer, hold, abort and loop control
//
// Purpose:
//   Steps a 2-bit phase register through S0..S3 (00,01,10,11). Each phase lasts
//   DWELLn clock cycles unless frozen by hold or cut short by abort. After S3 the
//   sequence either restarts at S0 (loop=1) or returns to idle (loop=0).
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a sequence; only sampled while idle
//   hold         in   freeze timer, phase and busy while high
//   abort        in   synchronous return to idle (highest priority)
//   loop         in   1 = restart at S0 after S3, 0 = stop; sampled at S3 expiry
//   currstate    out  registered current phase
//   nextstate    out  combinational value currstate takes at the next edge
//   busy         out  high while a sequence is running
//   phase_done   out  one-cycle pulse on the first cycle of a new phase
//   cycle_done   out  one-cycle pulse on the cycle after S3 expires
//   cycle_count  out  number of completed S3 expirations (wraps at 255)

module phase_sequencer #(
  parameter int CNT_W  = 8,
  parameter int DWELL0 = 2,
  parameter int DWELL1 = 3,
  parameter int DWELL2 = 1,
  parameter int DWELL3 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hold,
  input  logic       abort,
  input  logic       loop,
  output logic [1:0] currstate,
  output logic [1:0] nextstate,
  output logic       busy,
  output logic       phase_done,
  output logic       cycle_done,
  output logic [7:0] cycle_count
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t           state_q, state_d;
  state_t           phase_inc;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             phase_done_q, phase_done_d;
  logic             cycle_done_q, cycle_done_d;
  logic [7:0]       cycle_count_q, cycle_count_d;

  // The timer is loaded with DWELL-1 and the phase advances on the edge where
  // it reads zero, so a phase spans exactly DWELL cycles.
  function automatic logic [CNT_W-1:0] dwell_m1(input state_t s);
    case (s)
      S0:      dwell_m1 = CNT_W'(DWELL0 - 1);
      S1:      dwell_m1 = CNT_W'(DWELL1 - 1);
      S2:      dwell_m1 = CNT_W'(DWELL2 - 1);
      default: dwell_m1 = CNT_W'(DWELL3 - 1);
    endcase
  endfunction

  assign phase_inc = state_t'(state_q + 2'd1);

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    timer_d       = timer_q;
    phase_done_d  = 1'b0;
    cycle_done_d  = 1'b0;
    cycle_count_d = cycle_count_q;

    if (busy_q) begin
      if (abort) begin
        state_d = S0;
        busy_d  = 1'b0;
        timer_d = '0;
      end else if (!hold) begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          phase_done_d = 1'b1;
          if (state_q == S3) begin
            cycle_done_d  = 1'b1;
            cycle_count_d = cycle_count_q + 8'd1;
            state_d       = S0;
            if (loop) begin
              timer_d = dwell_m1(S0);
            end else begin
              busy_d  = 1'b0;
              timer_d = '0;
            end
          end else begin
            state_d = phase_inc;
            timer_d = dwell_m1(phase_inc);
          end
        end
      end
    end else if (start && !abort && !hold) begin
      // Hold freezes busy as well, so a start seen under hold is dropped.
      busy_d  = 1'b1;
      timer_d = dwell_m1(S0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S0;
      busy_q        <= 1'b0;
      timer_q       <= '0;
      phase_done_q  <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      timer_q       <= timer_d;
      phase_done_q  <= phase_done_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign currstate   = state_q;
  assign nextstate   = state_d;
  assign busy        = busy_q;
  assign phase_done  = phase_done_q;
  assign cycle_done  = cycle_done_q;
  assign cycle_count = cycle_count_q;

endmodule
